matmat_sched: RTL

- Round-robin scheduler that shares one serial-input matrix-multiply engine between NUM_REQ requesters.
- The engine never returns from its process phase to its load phase on its own. The scheduler therefore grants one requester per job, pulses the engine reset, and streams that requester's matrix elements and vector elements into the engine.
- It tags each result vector with the owning requester ID and drains outstanding results before granting the next job.

---
 rtl/matmat_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/matmat_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/matmat_pkg.sv
// Shared types and default-configuration widths for the matrix-multiply scheduler.
package matmat_pkg;

  localparam int NUM_REQ_DEF      = 4;
  localparam int ELEMENTS_NUM_DEF = 4;
  localparam int ID_W   = $clog2(NUM_REQ_DEF);
  localparam int BEAT_W = $clog2(ELEMENTS_NUM_DEF * ELEMENTS_NUM_DEF + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    RSTENG = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_id = ptr;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[ptr + ID_W'(i)]) begin
        any    = 1'b1;
        gnt_id = ptr + ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/matmat_sched.sv
// Shares one serial matrix-multiply engine between NUM_REQ requesters, one job at a time.
//   state  | meaning
//   IDLE   | no job; wait for any request
//   ARB    | round-robin pick of the next owner
//   RSTENG | hold engine reset for RST_CYCLES
//   STREAM | forward owner's beats to the engine
//   DRAIN  | wait for outstanding results (bounded by DRAIN_TIMEOUT)
module matmat_sched
  import matmat_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ELEMENTS_NUM  = 4,
  parameter int DATA_WIDTH    = 4,
  parameter int RST_CYCLES    = 2,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          eng_rst,
  output logic [DATA_WIDTH-1:0]         eng_in,
  output logic                          eng_valid_in,
  input  logic                          eng_ready_in,
  input  logic                          eng_valid_out,
  output logic                          eng_ready_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  output logic                          busy,
  output logic                          proto_err,
  output logic                          timeout_err
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int E    = ELEMENTS_NUM;
  localparam int BW   = $clog2(E * E + 1);
  localparam int VPW  = (E > 1) ? $clog2(E) : 1;
  localparam int OUTW = 8;
  localparam int RCW  = $clog2(RST_CYCLES + 1);
  localparam int DCW  = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [BW-1:0]  MAT_BEATS  = BW'(E * E);
  localparam logic [VPW-1:0] VEC_LAST   = VPW'(E - 1);
  localparam logic [RCW-1:0] RST_LAST   = RCW'(RST_CYCLES - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);

  sched_state_t    state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [VPW-1:0]  vec_pos_q, vec_pos_d;
  logic [OUTW-1:0] outstanding_q, outstanding_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
  logic            proto_err_q, proto_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            retired_q, retired_d;

  logic [IDW-1:0]  arb_gnt;
  logic            arb_any;
  logic            in_stream, in_result, beat, mat_done, at_vec_end;
  logic            vec_done, last_legal, last_illegal, retire;

  rr_arbiter #(.N(NUM_REQ), .ID_W(IDW)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt_id (arb_gnt),
    .any    (arb_any)
  );

  always_comb begin
    in_stream    = (state_q == STREAM);
    in_result    = (state_q == STREAM) || (state_q == DRAIN);
    beat         = in_stream && req_valid[grant_id_q] && eng_ready_in;
    mat_done     = (beat_cnt_q == MAT_BEATS);
    at_vec_end   = mat_done && (vec_pos_q == VEC_LAST);
    vec_done     = beat && at_vec_end;
    last_legal   = vec_done && req_last[grant_id_q];
    last_illegal = beat && req_last[grant_id_q] && !at_vec_end;
    // One retire per eng_valid_out high period, on its first accepted cycle.
    retire       = in_result && eng_valid_out && res_ready && !retired_q;
  end

  always_comb begin
    eng_rst       = rst || (state_q == RSTENG);
    eng_valid_in  = in_stream && req_valid[grant_id_q];
    eng_in        = in_stream ? req_data[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    req_ready     = (in_stream && eng_ready_in) ? (NUM_REQ'(1) << grant_id_q) : '0;
    res_valid     = in_result && eng_valid_out;
    eng_ready_out = in_result && res_ready;
    res_id        = in_result ? grant_id_q : '0;
    busy          = (state_q != IDLE);
    proto_err     = proto_err_q;
    timeout_err   = timeout_err_q;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    rst_cnt_d     = rst_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    vec_pos_d     = vec_pos_q;
    outstanding_d = outstanding_q;
    drain_cnt_d   = drain_cnt_q;
    proto_err_d   = proto_err_q;
    timeout_err_d = timeout_err_q;
    retired_d     = eng_valid_out && (retired_q || retire);

    if (vec_done && !retire && (outstanding_q != '1)) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (retire && !vec_done && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (|req_valid) state_d = ARB;
      end
      ARB: begin
        if (arb_any) begin
          grant_id_d = arb_gnt;
          rr_ptr_d   = arb_gnt + 1'b1;
          rst_cnt_d  = '0;
          state_d    = RSTENG;
        end else begin
          state_d = IDLE;
        end
      end
      RSTENG: begin
        beat_cnt_d    = '0;
        vec_pos_d     = '0;
        outstanding_d = '0;
        drain_cnt_d   = '0;
        if (rst_cnt_q == RST_LAST) state_d = STREAM;
        else                       rst_cnt_d = rst_cnt_q + 1'b1;
      end
      STREAM: begin
        if (beat) begin
          if (!mat_done) beat_cnt_d = beat_cnt_q + 1'b1;
          else           vec_pos_d  = (vec_pos_q == VEC_LAST) ? '0 : vec_pos_q + 1'b1;
        end
        if (last_illegal) proto_err_d = 1'b1;
        if (last_legal) begin
          drain_cnt_d = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = ARB;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ARB;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      rst_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      vec_pos_q     <= '0;
      outstanding_q <= '0;
      drain_cnt_q   <= '0;
      proto_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      retired_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      rst_cnt_q     <= rst_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      vec_pos_q     <= vec_pos_d;
      outstanding_q <= outstanding_d;
      drain_cnt_q   <= drain_cnt_d;
      proto_err_q   <= proto_err_d;
      timeout_err_q <= timeout_err_d;
      retired_q     <= retired_d;
    end
  end

endmodule
